// File: rtl/free_list.sv
// free_list: physical-register free list for a two-wide rename stage.
// Free tags are kept in a circular buffer with head (allocate) and tail
// (release) pointers. Head snapshots are held in checkpoint slots so that
// a branch mispredict can restore the list.
// Optional build macro: FREE_LIST_CHECK_EN enables the sticky fl_err
// over-release / bad-restore detector. Without it, fl_err is tied low.
module free_list #(
    parameter int P_ADDR_WIDTH = 7,
    parameter int L_ADDR_WIDTH = 5,
    parameter int C_NUM        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req_1,
    input  logic                     alloc_req_2,
    output logic [P_ADDR_WIDTH-1:0]  alloc_tag_1,
    output logic [P_ADDR_WIDTH-1:0]  alloc_tag_2,
    output logic                     alloc_ready,
    input  logic                     rel_en_1,
    input  logic                     rel_en_2,
    input  logic [P_ADDR_WIDTH-1:0]  rel_tag_1,
    input  logic [P_ADDR_WIDTH-1:0]  rel_tag_2,
    input  logic                     take_checkpoint,
    input  logic                     single_branch,
    input  logic                     dual_branch,
    input  logic                     instr_num,
    input  logic                     restore_en,
    input  logic [$clog2(C_NUM)-1:0] restore_id,
    output logic [P_ADDR_WIDTH-1:0]  free_count,
    output logic                     fl_err
);

    localparam int NUM_ENTRIES = 1 << P_ADDR_WIDTH;
    // Tags 0..2^L-1 start out as the architectural mappings, so only the
    // remaining tags are free at reset and the list can never hold more.
    localparam int FREE_LIMIT  = NUM_ENTRIES - (1 << L_ADDR_WIDTH);
    localparam int ID_W        = $clog2(C_NUM);

    typedef logic [P_ADDR_WIDTH-1:0] tag_t;
    typedef logic [ID_W-1:0]         id_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tag_t tag_mem_q [NUM_ENTRIES];
    tag_t tag_mem_d [NUM_ENTRIES];
    tag_t head_q, head_d;
    tag_t tail_q, tail_d;
    id_t  ckp_id_q, ckp_id_d;
    tag_t ckp_q [C_NUM];
    tag_t ckp_d [C_NUM];

    // ------------------------------------------------------------------
    // Allocation side
    // ------------------------------------------------------------------
    tag_t       head_p1;
    tag_t       tail_p1;
    logic       grant;
    logic [1:0] alloc_cnt;
    logic [1:0] rel_cnt;
    tag_t       head_after_1;
    tag_t       head_after_2;

    assign head_p1     = head_q + tag_t'(1);
    assign tail_p1     = tail_q + tag_t'(1);
    assign free_count  = tail_q - head_q;
    assign alloc_ready = (free_count >= tag_t'(2));
    assign grant       = alloc_ready & ~restore_en;

    // Slot 2 takes the next tag after slot 1 only when slot 1 consumes one.
    assign alloc_tag_1 = tag_mem_q[head_q];
    assign alloc_tag_2 = alloc_req_1 ? tag_mem_q[head_p1] : tag_mem_q[head_q];

    assign alloc_cnt    = grant ? ({1'b0, alloc_req_1} + {1'b0, alloc_req_2}) : 2'd0;
    assign rel_cnt      = {1'b0, rel_en_1} + {1'b0, rel_en_2};
    assign head_after_1 = head_q + tag_t'(grant & alloc_req_1);
    assign head_after_2 = head_q + tag_t'(alloc_cnt);

    // Next head/tail: restore overrides allocation, releases always land.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        head_d = head_after_2;
        if (restore_en) begin
            head_d = ckp_q[restore_id];
        end
        tail_d = tail_q + tag_t'(rel_cnt);
    end

    // Release writes into the buffer at the tail, packed in order.
    always_comb begin
        tag_mem_d = tag_mem_q;
        if (rel_en_1) begin
            tag_mem_d[tail_q] = rel_tag_1;
        end
        if (rel_en_2) begin
            tag_mem_d[rel_en_1 ? tail_p1 : tail_q] = rel_tag_2;
        end
    end

    // Checkpoint capture; the saved head reflects only granted allocations.
    always_comb begin
        ckp_d    = ckp_q;
        ckp_id_d = ckp_id_q;
        if (take_checkpoint && !restore_en) begin
            if (dual_branch) begin
                ckp_d[ckp_id_q]             = head_after_1;
                ckp_d[ckp_id_q + id_t'(1)]  = head_after_2;
                ckp_id_d                    = ckp_id_q + id_t'(1) + id_t'(1);
            end else if (single_branch) begin
                ckp_d[ckp_id_q] = instr_num ? head_after_2 : head_after_1;
                ckp_id_d        = ckp_id_q + id_t'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------

    // Pointers and checkpoint index, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            head_q   <= '0;
            tail_q   <= tag_t'(FREE_LIMIT);
            ckp_id_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            ckp_id_q <= ckp_id_d;
        end
    end

    // Tag buffer: reset preloads the initially free tags in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FREE_LIMIT; i++) begin
                tag_mem_q[i] <= tag_t'((1 << L_ADDR_WIDTH) + i);
            end
        end else begin
            tag_mem_q <= tag_mem_d;
        end
    end

    // Checkpoint slots hold data only; they are written before any restore.
    always_ff @(posedge clk) begin
        // NOTE: this storage is deliberately not reset; a slot is always
        // written by a checkpoint before a restore can read it.
        ckp_q <= ckp_d;
    end

`ifdef FREE_LIST_CHECK_EN
    // ------------------------------------------------------------------
    // Error detection: the free count must never exceed FREE_LIMIT.
    // ------------------------------------------------------------------
    typedef logic [P_ADDR_WIDTH:0] cnt_t;
    localparam cnt_t LIMIT_C = cnt_t'(FREE_LIMIT);

    logic fl_err_q, fl_err_d;
    cnt_t next_count;

    // One extra bit keeps an over-release from wrapping back into range.
    always_comb begin
        next_count = {1'b0, free_count} + cnt_t'(rel_cnt) - cnt_t'(alloc_cnt);
        if (restore_en) begin
            next_count = {1'b0, tail_d - head_d};
        end
        fl_err_d = fl_err_q | (next_count > LIMIT_C);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fl_err_q <= 1'b0;
        end else begin
            fl_err_q <= fl_err_d;
        end
    end

    assign fl_err = fl_err_q;
`else
    assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed test of free_list. The driver applies one vector
// per cycle and queues the hand-computed outputs expected in that cycle;
// a separate monitor pops the queue and compares against the DUT.
module tb_free_list;

    localparam int P = 7;
    localparam int L = 5;
    localparam int C = 2;

`ifdef FREE_LIST_CHECK_EN
    localparam int ERR_ON_OVERFLOW = 1;
`else
    localparam int ERR_ON_OVERFLOW = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_req_1, alloc_req_2;
    logic [P-1:0] alloc_tag_1, alloc_tag_2;
    logic         alloc_ready;
    logic         rel_en_1, rel_en_2;
    logic [P-1:0] rel_tag_1, rel_tag_2;
    logic         take_checkpoint, single_branch, dual_branch, instr_num;
    logic         restore_en;
    logic [$clog2(C)-1:0] restore_id;
    logic [P-1:0] free_count;
    logic         fl_err;

    always #5 clk = ~clk;

    free_list #(.P_ADDR_WIDTH(P), .L_ADDR_WIDTH(L), .C_NUM(C)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req_1     (alloc_req_1),
        .alloc_req_2     (alloc_req_2),
        .alloc_tag_1     (alloc_tag_1),
        .alloc_tag_2     (alloc_tag_2),
        .alloc_ready     (alloc_ready),
        .rel_en_1        (rel_en_1),
        .rel_en_2        (rel_en_2),
        .rel_tag_1       (rel_tag_1),
        .rel_tag_2       (rel_tag_2),
        .take_checkpoint (take_checkpoint),
        .single_branch   (single_branch),
        .dual_branch     (dual_branch),
        .instr_num       (instr_num),
        .restore_en      (restore_en),
        .restore_id      (restore_id),
        .free_count      (free_count),
        .fl_err          (fl_err)
    );

    typedef enum {K_TAG1, K_TAG2, K_READY, K_COUNT, K_ERR} kind_e;
    typedef struct {
        string name;
        kind_e kind;
        int    value;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   exp_err      = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle after the driver.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                case (e.kind)
                    K_TAG1:  check({e.name, ".tag1"},  32'(alloc_tag_1), e.value);
                    K_TAG2:  check({e.name, ".tag2"},  32'(alloc_tag_2), e.value);
                    K_READY: check({e.name, ".ready"}, 32'(alloc_ready), e.value);
                    K_COUNT: check({e.name, ".count"}, 32'(free_count),  e.value);
                    default: check({e.name, ".err"},   32'(fl_err),      e.value);
                endcase
            end
        end
    end

    task automatic clear_inputs();
        rst = 1'b0;
        alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
        rel_en_1 = 1'b0; rel_en_2 = 1'b0;
        rel_tag_1 = '0; rel_tag_2 = '0;
        take_checkpoint = 1'b0; single_branch = 1'b0;
        dual_branch = 1'b0; instr_num = 1'b0;
        restore_en = 1'b0; restore_id = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic expect_out(input string name, input int t1, input int t2,
                              input int rdy, input int cnt);
        sb_q.push_back('{name, K_TAG1,  t1});
        sb_q.push_back('{name, K_TAG2,  t2});
        sb_q.push_back('{name, K_READY, rdy});
        sb_q.push_back('{name, K_COUNT, cnt});
        sb_q.push_back('{name, K_ERR,   exp_err});
    endtask

    // Reset with every other input active to show reset wins.
    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        alloc_req_1 = 1'b1; alloc_req_2 = 1'b1;
        rel_en_1 = 1'b1; rel_tag_1 = 7'd99;
        rel_en_2 = 1'b1; rel_tag_2 = 7'd98;
        restore_en = 1'b1; restore_id = 1'b1;
        take_checkpoint = 1'b1; dual_branch = 1'b1;
        exp_err = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // Reset state and paired allocation.
        do_reset();
        next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1; expect_out("post_reset", 32, 33, 1, 96);
        next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1; expect_out("second_pair", 34, 35, 1, 94);
        next_cycle(); expect_out("idle_after", 36, 36, 1, 92);

        // Only slot 2 requesting.
        do_reset();
        next_cycle(); alloc_req_2 = 1; expect_out("req2_only", 32, 32, 1, 96);
        next_cycle(); expect_out("after_req2", 33, 33, 1, 95);

        // Single-branch checkpoint then restore.
        do_reset();
        next_cycle(); take_checkpoint = 1; single_branch = 1; alloc_req_1 = 1; alloc_req_2 = 1;
        expect_out("ckp_single", 32, 33, 1, 96);
        next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1; expect_out("alloc_a", 34, 35, 1, 94);
        next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1; expect_out("alloc_b", 36, 37, 1, 92);
        next_cycle(); restore_en = 1; restore_id = 0; alloc_req_1 = 1; alloc_req_2 = 1;
        expect_out("restore_cycle", 38, 39, 1, 90);
        next_cycle(); alloc_req_1 = 1; expect_out("after_restore", 33, 34, 1, 95);

        // Dual-branch checkpoint, index wrap, instr_num=1, ignored checkpoint.
        do_reset();
        next_cycle(); take_checkpoint = 1; dual_branch = 1; alloc_req_1 = 1; alloc_req_2 = 1;
        expect_out("ckp_dual", 32, 33, 1, 96);
        next_cycle(); take_checkpoint = 1; single_branch = 1; instr_num = 1; alloc_req_2 = 1;
        expect_out("ckp_single_i1", 34, 34, 1, 94);
        next_cycle(); restore_en = 1; restore_id = 1; expect_out("restore1", 35, 35, 1, 93);
        next_cycle(); restore_en = 1; restore_id = 0; expect_out("restore0", 34, 34, 1, 94);
        next_cycle(); take_checkpoint = 1; single_branch = 1; alloc_req_1 = 1;
        expect_out("restored_head", 35, 36, 1, 93);
        next_cycle(); restore_en = 1; restore_id = 1; take_checkpoint = 1; single_branch = 1;
        alloc_req_1 = 1; alloc_req_2 = 1; expect_out("ign_ckp_a", 36, 37, 1, 92);
        next_cycle(); restore_en = 1; restore_id = 0; expect_out("ign_ckp_b", 36, 36, 1, 92);
        next_cycle(); expect_out("ign_ckp_c", 35, 35, 1, 93);

        // Release during allocation, wrap, stall, restore with release.
        do_reset();
        next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1; expect_out("wrap_a", 32, 33, 1, 96);
        next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1;
        rel_en_1 = 1; rel_tag_1 = 7'd40; rel_en_2 = 1; rel_tag_2 = 7'd41;
        expect_out("rel_alloc", 34, 35, 1, 94);
        for (int h = 4; h < 96; h += 2) begin
            next_cycle(); alloc_req_1 = 1; alloc_req_2 = 1;
            expect_out("drain", 32 + h, 33 + h, 1, 98 - h);
        end
        next_cycle(); alloc_req_1 = 1; expect_out("wrap_tags", 40, 41, 1, 2);
        next_cycle(); alloc_req_2 = 1; take_checkpoint = 1; single_branch = 1;
        expect_out("stall", 41, 41, 0, 1);
        next_cycle(); alloc_req_2 = 1; expect_out("stall_held", 41, 41, 0, 1);
        next_cycle(); restore_en = 1; restore_id = 0; alloc_req_2 = 1;
        rel_en_2 = 1; rel_tag_2 = 7'd50; expect_out("restore_rel", 41, 41, 0, 1);
        next_cycle(); alloc_req_1 = 1; expect_out("post_rel", 41, 50, 1, 2);
        next_cycle(); expect_out("final_head", 50, 50, 0, 1);

        // Over-release right after reset.
        do_reset();
        next_cycle(); rel_en_1 = 1; rel_tag_1 = 7'd5; rel_en_2 = 1; rel_tag_2 = 7'd6;
        expect_out("over_rel", 32, 32, 1, 96);
        exp_err = ERR_ON_OVERFLOW;
        next_cycle(); expect_out("err_set", 32, 32, 1, 98);
        next_cycle(); expect_out("err_sticky", 32, 32, 1, 98);
        do_reset();
        next_cycle(); expect_out("err_cleared", 32, 32, 1, 96);

        next_cycle();
        next_cycle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
